// File: rtl/ram_dump_pkg.sv
// Shared constants and FSM state encoding for the RAM dump reader.
// Every frame starts with HEADER_BYTE.
package ram_dump_pkg;

    localparam logic [7:0] HEADER_BYTE = 8'hAA;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        FETCH,
        LOAD,
        SEND,
        DONE
    } state_t;

endpackage

// File: rtl/word_serializer.sv
// Splits one SIZE-bit word into little-endian bytes for the serial transmitter.
// Owns the tx strobe and the guard cycle that follows every strobe.
module word_serializer
    import ram_dump_pkg::*;
#(
    parameter int SIZE = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [SIZE-1:0] load_data,
    input  logic            header_req,
    input  logic            send_en,
    input  logic            tx_busy,
    output logic [7:0]      tx_data,
    output logic            new_tx_data,
    output logic            header_sent,
    output logic            word_done
);

    localparam int BYTES = SIZE / 8;
    localparam int BW    = $clog2(BYTES + 1);

    logic [SIZE-1:0] shift_reg;
    logic [SIZE-1:0] shift_next;
    logic [BW-1:0]   bytes_left_reg;
    logic [7:0]      tx_data_reg;
    logic            strobe_reg;
    logic            can_strobe;
    logic            byte_fire;

    // Byte lanes move down by one; the top lane refills with zero.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            if (gi == BYTES - 1) begin : g_top
                assign shift_next[gi*8 +: 8] = 8'h00;
            end else begin : g_mid
                assign shift_next[gi*8 +: 8] = shift_reg[(gi+1)*8 +: 8];
            end
        end
    endgenerate

    // The strobe register doubles as the guard: the transmitter raises
    // tx_busy one cycle late, so the cycle after a strobe is always skipped.
    assign can_strobe  = !tx_busy && !strobe_reg;
    assign header_sent = header_req && can_strobe;
    assign byte_fire   = send_en && (bytes_left_reg != '0) && can_strobe;
    assign word_done   = send_en && (bytes_left_reg == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg      <= '0;
            bytes_left_reg <= '0;
            tx_data_reg    <= '0;
            strobe_reg     <= 1'b0;
        end else begin
            strobe_reg <= header_sent || byte_fire;
            if (load) begin
                shift_reg      <= load_data;
                bytes_left_reg <= BW'(BYTES);
            end else if (byte_fire) begin
                shift_reg      <= shift_next;
                bytes_left_reg <= bytes_left_reg - BW'(1);
            end
            if (header_sent) begin
                tx_data_reg <= HEADER_BYTE;
            end else if (byte_fire) begin
                tx_data_reg <= shift_reg[7:0];
            end
        end
    end

    assign tx_data     = tx_data_reg;
    assign new_tx_data = strobe_reg;

endmodule

// File: rtl/ram_dump_reader.sv
// Walks a window of the count RAM and streams it as one header-prefixed frame
// of little-endian bytes to the serial transmitter.
module ram_dump_reader
    import ram_dump_pkg::*;
#(
    parameter int SIZE  = 64,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [$clog2(DEPTH)-1:0] start_addr,
    input  logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH)-1:0] raddr,
    input  logic [SIZE-1:0]          read_data,
    output logic [7:0]               tx_data,
    output logic                     new_tx_data,
    input  logic                     tx_busy,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_t          state_reg;
    state_t          state_next;
    logic [AW-1:0]   addr_reg;
    logic [AW-1:0]   addr_next;
    logic [AW-1:0]   addr_inc;
    logic [CW-1:0]   words_reg;
    logic [CW-1:0]   words_next;
    logic [CW-1:0]   count_clamped;
    logic            busy_reg;
    logic            done_reg;

    logic            ser_load;
    logic            header_req;
    logic            send_en;
    logic            header_sent;
    logic            word_done;

    assign count_clamped = (count > CW'(DEPTH)) ? CW'(DEPTH) : count;
    assign addr_inc      = (addr_reg == AW'(DEPTH - 1)) ? '0 : addr_reg + AW'(1);

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        words_next = words_reg;
        ser_load   = 1'b0;
        header_req = 1'b0;
        send_en    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    addr_next  = start_addr;
                    words_next = count_clamped;
                    state_next = (count == '0) ? DONE : HEADER;
                end
            end
            HEADER: begin
                header_req = 1'b1;
                if (header_sent) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = LOAD;
            end
            LOAD: begin
                ser_load   = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                send_en = 1'b1;
                if (word_done) begin
                    if (words_reg > CW'(1)) begin
                        addr_next  = addr_inc;
                        words_next = words_reg - CW'(1);
                        state_next = FETCH;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // busy/done are registered from the next state so busy drops exactly
    // when the done pulse appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            words_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            words_reg <= words_next;
            busy_reg  <= (state_next == HEADER) || (state_next == FETCH) ||
                         (state_next == LOAD)   || (state_next == SEND);
            done_reg  <= (state_next == DONE);
        end
    end

    word_serializer #(
        .SIZE(SIZE)
    ) u_serializer (
        .clk         (clk),
        .rst         (rst),
        .load        (ser_load),
        .load_data   (read_data),
        .header_req  (header_req),
        .send_en     (send_en),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .header_sent (header_sent),
        .word_done   (word_done)
    );

    assign raddr = addr_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_ram_dump_reader.sv
// Directed bench for ram_dump_reader: RAM model, byte-stream monitor, frame checks.
module tb_ram_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  start_addr;
    logic [6:0]  count;
    logic [5:0]  raddr;
    logic [63:0] read_data = '0;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        tx_busy = 1'b0;
    logic        busy;
    logic        done;

    logic [63:0] ram [0:63];

    int n_checks = 0;
    int n_fail   = 0;

    int       cyc = 0;
    logic     busy_edge = 1'b0;
    logic [7:0] rx_q[$];
    int       rx_t[$];
    int       ra_q[$];
    logic     ra_valid = 1'b0;
    logic [5:0] ra_last = '0;
    int       done_cnt = 0;
    int       done_cyc = 0;
    logic     done_busy = 1'b0;
    int       bp_viol = 0;
    int       bp_cnt = 0;
    bit       bp_en = 1'b0;
    int       done_ref = 0;
    int       start_cyc = 0;

    always #5 clk = ~clk;

    ram_dump_reader #(
        .SIZE(64),
        .DEPTH(64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_addr  (start_addr),
        .count       (count),
        .raddr       (raddr),
        .read_data   (read_data),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy),
        .busy        (busy),
        .done        (done)
    );

    always @(posedge clk) begin
        read_data <= ram[raddr];
        cyc       <= cyc + 1;
        busy_edge <= tx_busy;
    end

    always @(negedge clk) begin
        if (new_tx_data) begin
            rx_q.push_back(tx_data);
            rx_t.push_back(cyc);
            if (busy_edge) bp_viol++;
        end
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = busy;
        end
        if (busy && (!ra_valid || raddr != ra_last)) begin
            ra_q.push_back(int'(raddr));
            ra_last  = raddr;
            ra_valid = 1'b1;
        end
        if (bp_en && new_tx_data) bp_cnt = 10;
        else if (bp_cnt > 0)      bp_cnt--;
        tx_busy = (bp_cnt > 0);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ram_byte(input int w, input int k);
        logic [63:0] word;
        word = ram[w % 64];
        return word[k*8 +: 8];
    endfunction

    task automatic start_dump(input int a, input int c, input bit clr);
        @(posedge clk);
        if (clr) begin
            rx_q.delete();
            rx_t.delete();
            ra_q.delete();
            ra_valid = 1'b0;
        end
        @(negedge clk);
        start      = 1'b1;
        start_addr = 6'(a);
        count      = 7'(c);
        @(posedge clk);
        done_ref = done_cnt;
        @(negedge clk);
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string tag, input int limit);
        bit got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            if (done_cnt != done_ref) begin
                got = 1'b1;
                break;
            end
        end
        check_val({tag, "_done_seen"}, 64'(got), 64'd1);
    endtask

    task automatic check_frame(input string tag, input int a, input int n);
        int exp_len = 1 + 8 * n;
        logic [7:0] exp;
        check_val({tag, "_len"}, 64'(rx_q.size()), 64'(exp_len));
        for (int i = 0; i < rx_q.size() && i < exp_len; i++) begin
            exp = (i == 0) ? 8'hAA : ram_byte(a + (i - 1) / 8, (i - 1) % 8);
            check_val($sformatf("%s_b%0d", tag, i), 64'(rx_q[i]), 64'(exp));
        end
    endtask

    initial begin
        int bad;
        int n;
        bit reached;

        rst = 1'b1;
        start = 1'b0;
        start_addr = '0;
        count = '0;
        for (int w = 0; w < 64; w++)
            for (int k = 0; k < 8; k++)
                ram[w][k*8 +: 8] = 8'(w * 37 + k * 11 + 3);
        ram[5] = 64'h0807060504030201;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_raddr", 64'(raddr), 64'd0);
        check_val("rst_tx_data", 64'(tx_data), 64'd0);
        check_val("rst_new_tx_data", 64'(new_tx_data), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        rst = 1'b0;

        // Single word, no backpressure: exact timing
        start_dump(5, 1, 1'b1);
        check_val("t1_busy_cycle1", 64'(busy), 64'd1);
        wait_done("t1", 200);
        check_frame("t1", 5, 1);
        if (rx_t.size() == 9) begin
            check_val("t1_header_rel", 64'(rx_t[0] - start_cyc), 64'd1);
            bad = 0;
            for (int i = 2; i < 9; i++) if (rx_t[i] - rx_t[i-1] != 2) bad++;
            check_val("t1_data_gap_bad", 64'(bad), 64'd0);
            check_val("t1_done_after_last", 64'(done_cyc - rx_t[8]), 64'd1);
        end else begin
            check_val("t1_tstamps", 64'(rx_t.size()), 64'd9);
        end
        check_val("t1_busy_at_done", 64'(done_busy), 64'd0);

        // Wrap-around 63,0,1
        start_dump(63, 3, 1'b1);
        wait_done("t2", 300);
        check_frame("t2", 63, 3);
        check_val("t2_raddr_n", 64'(ra_q.size()), 64'd3);
        if (ra_q.size() == 3) begin
            check_val("t2_raddr0", 64'(ra_q[0]), 64'd63);
            check_val("t2_raddr1", 64'(ra_q[1]), 64'd0);
            check_val("t2_raddr2", 64'(ra_q[2]), 64'd1);
        end
        if (rx_t.size() >= 10)
            check_val("t2_word_period", 64'(rx_t[9] - rx_t[1]), 64'd18);

        // Backpressure: 10 busy cycles after each strobe
        bp_en = 1'b1;
        bp_viol = 0;
        start_dump(10, 2, 1'b1);
        wait_done("t3", 2000);
        check_frame("t3", 10, 2);
        check_val("t3_strobe_while_busy", 64'(bp_viol), 64'd0);
        bp_en = 1'b0;
        repeat (12) @(posedge clk);

        // count=0: no bytes, done right after start
        start_dump(9, 0, 1'b1);
        wait_done("t4", 20);
        check_val("t4_no_bytes", 64'(rx_q.size()), 64'd0);
        check_val("t4_done_rel", 64'(done_cyc - start_cyc), 64'd0);
        check_val("t4_never_busy", 64'(ra_q.size()), 64'd0);

        // count=100 clamps to 64 words
        start_dump(7, 100, 1'b1);
        wait_done("t5", 3000);
        check_frame("t5", 7, 64);

        // Start while busy is ignored
        start_dump(20, 2, 1'b1);
        repeat (15) @(posedge clk);
        start_dump(40, 5, 1'b0);
        wait_done("t6", 300);
        check_frame("t6", 20, 2);
        n = rx_q.size();
        repeat (60) @(posedge clk);
        check_val("t6_no_second_frame", 64'(rx_q.size()), 64'(n));
        check_val("t6_idle_after", 64'(busy), 64'd0);

        // Reset after the 3rd data byte, then a fresh full frame
        start_dump(3, 2, 1'b1);
        reached = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (rx_q.size() >= 4) begin
                reached = 1'b1;
                break;
            end
        end
        check_val("t7_reached_byte3", 64'(reached), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("t7_raddr", 64'(raddr), 64'd0);
        check_val("t7_tx_data", 64'(tx_data), 64'd0);
        check_val("t7_new_tx_data", 64'(new_tx_data), 64'd0);
        check_val("t7_busy", 64'(busy), 64'd0);
        check_val("t7_done", 64'(done), 64'd0);
        rst = 1'b0;
        start_dump(3, 1, 1'b1);
        wait_done("t7b", 200);
        check_frame("t7b", 3, 1);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
